// File: rtl/lab_div_seq_if.sv
// lab_div_seq_if: request/result bundle between a requester and the sequential divider
interface lab_div_seq_if #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
);
    logic               in_valid;
    logic [WIDTH_A-1:0] in_dividend;
    logic [WIDTH_B-1:0] in_divisor;
    logic               busy;
    logic [WIDTH_A-1:0] quotient;
    logic [WIDTH_B-1:0] remainder;
    logic               div_zero;
    logic               out_valid;

    modport master (
        output in_valid, in_dividend, in_divisor,
        input  busy, quotient, remainder, div_zero, out_valid
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor,
        output busy, quotient, remainder, div_zero, out_valid
    );
endinterface

// File: rtl/lab_div_seq.sv
// lab_div_seq: sequential unsigned restoring divider, one quotient bit per clock
module lab_div_seq #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
) (
    input  logic         CLK,
    input  logic         reset_n,
    lab_div_seq_if.slave bus
);
    localparam int CW = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic [WIDTH_B:0]   p;
    logic [WIDTH_A-1:0] q;
    logic [WIDTH_B-1:0] divisor;
    logic [WIDTH_A-1:0] quotient;
    logic [WIDTH_B-1:0] remainder;
    logic               div_zero;
    logic [WIDTH_B:0]   t, p_nxt;
    logic [WIDTH_A-1:0] q_nxt;
    logic               ge, last, accept;

    assign accept        = (state == IDLE) && bus.in_valid;
    assign last          = count == CW'(WIDTH_A - 1);
    assign bus.busy      = state != IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.div_zero  = div_zero;

    // one restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        t     = {p[WIDTH_B-1:0], q[WIDTH_A-1]};
        ge    = t >= {1'b0, divisor};
        p_nxt = ge ? t - {1'b0, divisor} : t;
        q_nxt = (q << 1) | WIDTH_A'(ge);
    end

    // state register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state: fixed WIDTH_A iterations, then a single result cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.in_valid ? CALC : IDLE;
            CALC:    state_nxt = last ? DONE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: capture on accept, iterate in CALC, publish on the last step
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            p         <= '0;
            q         <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            count     <= '0;
            p         <= '0;
            q         <= bus.in_dividend;
            divisor   <= bus.in_divisor;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state == CALC) begin
            count <= count + 1'b1;
            p     <= p_nxt;
            q     <= q_nxt;
            if (last) begin
                quotient  <= q_nxt;
                remainder <= p_nxt[WIDTH_B-1:0];
                div_zero  <= divisor == '0;
            end
        end
    end
endmodule

// File: tb/tb_lab_div_seq.sv
// tb_lab_div_seq: table and scoreboard driven check of the sequential divider
module tb_lab_div_seq;
    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulses = 0;

    lab_div_seq_if #(.WIDTH_A(16), .WIDTH_B(8)) bus ();

    lab_div_seq #(.WIDTH_A(16), .WIDTH_B(8)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s op%0d: got %0h expected %0h", nm, id, act, req);
        end
    endtask

    // scoreboard: every result pulse is matched against the oldest outstanding request
    always @(negedge CLK) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got q=%0h r=%0h expected no pulse", bus.quotient, bus.remainder);
            end else begin
                e = sb.pop_front();
                check("quotient", e.id, 32'(bus.quotient), 32'(e.q));
                check("remainder", e.id, 32'(bus.remainder), 32'(e.r));
                check("div_zero", e.id, 32'(bus.div_zero), 32'(e.dz));
                check("latency", e.id, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int id);
        exp_t e;
        e.q   = (b == 0) ? 16'hFFFF : a / 16'(b);
        e.r   = (b == 0) ? a[7:0] : 8'(a % 16'(b));
        e.dz  = b == 0;
        e.cyc = 0;
        e.id  = id;
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) check("idle_timeout", -1, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input exp_t e);
        wait_idle();
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        e.cyc = cyc + 17;
        sb.push_back(e);
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("drain_timeout", -1, 32'(sb.size()), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   p0;
        logic [15:0] ra;
        logic [7:0]  rb;
        tbl[0]  = '{16'd27,    8'd3,   16'd9,     8'd0,   1'b0};
        tbl[1]  = '{16'd861,   8'd7,   16'd123,   8'd0,   1'b0};
        tbl[2]  = '{16'd862,   8'd7,   16'd123,   8'd1,   1'b0};
        tbl[3]  = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0};
        tbl[4]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
        tbl[5]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
        tbl[6]  = '{16'd840,   8'd60,  16'd14,    8'd0,   1'b0};
        tbl[7]  = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1};
        tbl[8]  = '{16'd10,    8'd14,  16'd0,     8'd10,  1'b0};
        tbl[9]  = '{16'd255,   8'd16,  16'd15,    8'd15,  1'b0};
        tbl[10] = '{16'd65535, 8'd2,   16'd32767, 8'd1,   1'b0};
        tbl[11] = '{16'd1000,  8'd255, 16'd3,     8'd235, 1'b0};
        tbl[12] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1};

        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 0, 32'(bus.busy), 32'd0);
        check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
        check("rst_quotient", 0, 32'(bus.quotient), 32'd0);
        check("rst_remainder", 0, 32'(bus.remainder), 32'd0);
        check("rst_div_zero", 0, 32'(bus.div_zero), 32'd0);
        reset_n = 1'b1;
        @(negedge CLK);

        p0 = pulses;
        for (int i = 0; i < 13; i++) begin
            e = '{q: tbl[i].q, r: tbl[i].r, dz: tbl[i].dz, cyc: 0, id: i};
            do_op(tbl[i].a, tbl[i].b, e);
        end
        drain();
        check("table_pulses", 100, 32'(pulses - p0), 32'd13);

        repeat (5) @(negedge CLK);
        check("hold_quotient", 101, 32'(bus.quotient), 32'hFFFF);
        check("hold_div_zero", 101, 32'(bus.div_zero), 32'd1);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            do_op(ra, rb, model(ra, rb, 200 + i));
        end
        drain();

        wait_idle();
        p0 = pulses;
        bus.in_valid    = 1'b1;
        bus.in_dividend = 16'd27;
        bus.in_divisor  = 8'd3;
        sb.push_back('{q: 16'd9, r: 8'd0, dz: 1'b0, cyc: cyc + 17, id: 300});
        @(negedge CLK);
        bus.in_dividend = 16'd100;
        bus.in_divisor  = 8'd10;
        repeat (10) @(negedge CLK);
        bus.in_valid = 1'b0;
        drain();
        check("busy_ignore_pulses", 300, 32'(pulses - p0), 32'd1);

        wait_idle();
        p0 = pulses;
        bus.in_valid    = 1'b1;
        bus.in_dividend = 16'd861;
        bus.in_divisor  = 8'd7;
        sb.push_back('{q: 16'd123, r: 8'd0, dz: 1'b0, cyc: cyc + 17, id: 400});
        sb.push_back('{q: 16'd123, r: 8'd0, dz: 1'b0, cyc: cyc + 35, id: 401});
        repeat (19) @(negedge CLK);
        bus.in_valid = 1'b0;
        drain();
        check("held_valid_pulses", 400, 32'(pulses - p0), 32'd2);

        wait_idle();
        bus.in_valid    = 1'b1;
        bus.in_dividend = 16'd100;
        bus.in_divisor  = 8'd7;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge CLK);
        p0 = pulses;
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 500, 32'(bus.busy), 32'd0);
        check("abort_out_valid", 500, 32'(bus.out_valid), 32'd0);
        check("abort_quotient", 500, 32'(bus.quotient), 32'd0);
        check("abort_remainder", 500, 32'(bus.remainder), 32'd0);
        check("abort_div_zero", 500, 32'(bus.div_zero), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (25) @(negedge CLK);
        check("abort_no_pulse", 500, 32'(pulses - p0), 32'd0);
        do_op(16'd10, 8'd14, '{q: 16'd0, r: 8'd10, dz: 1'b0, cyc: 0, id: 501});
        drain();

        check("scoreboard_empty", 600, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
